zx_kbd_spi_rx: RTL and testbench
================================

// Module: zx_kbd_spi_rx
// PURPOSE
//  - SPI slave receiver for the keyboard frame sent by the USB/PS2/SEGA controller on KBD_CS/KBD_CLK/KBD_DI.
//  - Holds the 8x5 ZX key matrix and decodes KD[4:0] for the current high address byte.
//  - KD feeds the port #FE read data, bits [4:0]. This block sits directly upstream of the port #FE decoder.
//  - Also latches controller status bits: reset request, magic, turbo.
// PARAMETERS
//  SYNC_STAGES     2          flops per synchroniser on KBD_* inputs (>=2)
//  TIMEOUT_CYCLES  1400000    CLK_14MHZ cycles without a good frame before link drop (~100 ms)
//  ROWS            8          matrix rows, selected by A[15:8]
//  COLS            5          matrix columns, KD width
// PORTS
//  CLK_14MHZ      in   1   sole clock, all logic rising-edge
//  RESET          in   1   synchronous, active-high reset
//  KBD_CLK        in   1   SPI clock, async, data sampled on its rising edge
//  KBD_CS         in   1   SPI select, async, active-low frame envelope
//  KBD_DI         in   1   SPI data, async, MSB first
//  A_HI           in   8   CPU A[15:8], row select, active-low
//  KD             out  5   registered column data, active-low (0 = pressed)
//  KBD_RESET_REQ  out  1   status bit0, level
//  KBD_MAGIC      out  1   status bit1, level
//  KBD_TURBO      out  1   status bit2, level
//  LINK_UP        out  1   high while valid frames arrive within TIMEOUT_CYCLES
//  FRAME_OK       out  1   1-cycle pulse on commit of a good frame
//  FRAME_ERR      out  1   1-cycle pulse when a frame is discarded
// BEHAVIOUR
//  - Inputs pass SYNC_STAGES flops, then edge detect. Edges are seen SYNC_STAGES+1 cycles after the pins.
//  - Frame layout, FRAME_BITS = 48:
//    - 40 matrix bits first; bit index r*5+c; index 39 sent first; 0 = key down.
//    - then 8 status bits, MSB first.
//  - FSM IDLE -> SHIFT on KBD_CS falling: clear bit_cnt and shift register.
//    - SHIFT, KBD_CLK rising: shift in KBD_DI; bit_cnt saturates at FRAME_BITS+1.
//    - SHIFT -> CHECK on KBD_CS rising.
//    - CHECK -> IDLE after one cycle:
//      - bit_cnt == FRAME_BITS: commit matrix and status, FRAME_OK = 1, reload watchdog, LINK_UP = 1.
//      - otherwise: keep old data, FRAME_ERR = 1.
//  - KBD_CLK edges while KBD_CS is high are ignored.
//  - A KBD_CLK rise and a KBD_CS rise in the same cycle: the bit is shifted first, then CHECK is entered.
//  - KBD_CS falling while in CHECK: handled in IDLE on the next cycle; no edge is lost, the edge is held one cycle.
//  - Matrix is double-buffered. The shift register is never visible on KD; a commit is atomic.
//  - KD[c] <= AND over r of (matrix[r][c] | A_HI[r]); updated every cycle, 1-cycle latency from A_HI.
//    - A_HI = 8'hFF gives 5'h1F.
//  - Watchdog:
//    - decrements while nonzero; reloaded to TIMEOUT_CYCLES-1 on commit.
//    - at zero: matrix <= all 1s, status <= 0, LINK_UP <= 0.
//    - a commit in the same cycle wins.
//  - Reset values:
//    - KD = 5'h1F; status outputs, LINK_UP, FRAME_OK, FRAME_ERR = 0.
//    - FSM IDLE, matrix all 1s, watchdog 0.
//  - RESET mid-frame: frame dropped, no FRAME_ERR pulse; the next frame needs a fresh KBD_CS fall.
// CONFIGURATION
//  - Macro KBD_KEMPSTON_EN.
//  - When defined:
//    - FRAME_BITS = 56; a joystick byte follows the status byte.
//    - Extra port JOY, out, 8: Kempston data, active-high, bit0 = right.
//    - JOY commits with the frame; it is 8'h00 on reset and on watchdog expiry.
//  - When undefined: FRAME_BITS = 48, no JOY port, and a 56-bit frame is a FRAME_ERR.
// STRUCTURE
//  - Package zx_kbd_pkg:
//    - FRAME_BITS (both variants), MATRIX_BITS = 40, STATUS_BITS = 8, JOY_BITS = 8.
//    - Status bit indices; FSM state encoding IDLE/SHIFT/CHECK.
//  - Sub-module zx_kbd_sync: N-stage synchroniser plus rise/fall detect.
//    - Instantiated three times: KBD_CLK, KBD_CS, KBD_DI (DI without edge detect).
// TESTING
//  - Good frame: matrix all 1s except row 0 col 0 (CAPS), status 8'h00.
//    - A_HI = 8'hFE -> KD = 5'h1E; A_HI = 8'hFD -> 5'h1F; FRAME_OK pulses once; LINK_UP = 1.
//  - Multi-row: keys at r0c1 and r7c4, A_HI = 8'h7E -> KD = 5'h0D; A_HI = 8'h00 -> 5'h0D.
//  - Short frame (47 clocks) and long frame (49 clocks) -> FRAME_ERR pulse each, KD unchanged from the prior good frame.
//  - Status 8'h07 -> KBD_RESET_REQ = KBD_MAGIC = KBD_TURBO = 1.
//    - Then no frames for TIMEOUT_CYCLES (set to 1000 in bench) -> LINK_UP = 0, KD = 5'h1F, status 0.
//  - RESET asserted after 20 bits, released, full good frame sent -> only one FRAME_OK, no FRAME_ERR, data correct.
//  - KBD_KEMPSTON_EN build: 56-bit frame, joy byte 8'h11 -> JOY = 8'h11; same frame in the 48-bit build -> FRAME_ERR.

Source files
------------

// File: rtl/zx_kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zx_kbd_pkg
// Description : Shared frame geometry, status bit positions and receiver FSM
//               states for the ZX keyboard SPI receiver.
//               Macro KBD_KEMPSTON_EN selects the 56-bit frame variant.
// Revision    : 1.0 - initial release
// ============================================================================
package zx_kbd_pkg;

    localparam int MATRIX_BITS         = 40;
    localparam int STATUS_BITS         = 8;
    localparam int JOY_BITS            = 8;
    localparam int FRAME_BITS_STD      = MATRIX_BITS + STATUS_BITS;
    localparam int FRAME_BITS_KEMPSTON = FRAME_BITS_STD + JOY_BITS;

`ifdef KBD_KEMPSTON_EN
    localparam int FRAME_BITS = FRAME_BITS_KEMPSTON;
`else
    localparam int FRAME_BITS = FRAME_BITS_STD;
`endif

    localparam int STAT_RESET_REQ = 0;
    localparam int STAT_MAGIC     = 1;
    localparam int STAT_TURBO     = 2;
    localparam int STAT_KEEP      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/zx_kbd_sync.sv
`default_nettype none
// ============================================================================
// Module      : zx_kbd_sync
// Description : N-stage synchroniser for one asynchronous pin, with optional
//               rise/fall pulse outputs taken from the synchronised level.
// Revision    : 1.0 - initial release
// ============================================================================
module zx_kbd_sync #(
    parameter int STAGES    = 2,
    parameter bit RESET_VAL = 1'b0,
    parameter bit EDGE_DET  = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

    generate
        if (EDGE_DET) begin : g_edge
            logic prev_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    prev_q <= RESET_VAL;
                end else begin
                    prev_q <= sync_q[STAGES-1];
                end
            end

            assign rise_o =  sync_q[STAGES-1] & ~prev_q;
            assign fall_o = ~sync_q[STAGES-1] &  prev_q;
        end else begin : g_no_edge
            assign rise_o = 1'b0;
            assign fall_o = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/zx_kbd_spi_rx.sv
`default_nettype none
// ============================================================================
// Module      : zx_kbd_spi_rx
// Description : SPI slave receiving the keyboard frame, double-buffered 8x5
//               ZX matrix with port #FE column decode, status bits and link
//               watchdog. Macro KBD_KEMPSTON_EN adds the JOY byte and port.
// Revision    : 1.0 - initial release
// ============================================================================
module zx_kbd_spi_rx
    import zx_kbd_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1400000,
    parameter int ROWS           = 8,
    parameter int COLS           = 5
) (
    input  logic            CLK_14MHZ,
    input  logic            RESET,
    input  logic            KBD_CLK,
    input  logic            KBD_CS,
    input  logic            KBD_DI,
    input  logic [ROWS-1:0] A_HI,
    output logic [COLS-1:0] KD,
    output logic            KBD_RESET_REQ,
    output logic            KBD_MAGIC,
    output logic            KBD_TURBO,
    output logic            LINK_UP,
    output logic            FRAME_OK,
`ifdef KBD_KEMPSTON_EN
    output logic            FRAME_ERR,
    output logic [JOY_BITS-1:0] JOY
`else
    output logic            FRAME_ERR
`endif
);

    localparam int MAT_W      = ROWS * COLS;
    localparam int STATUS_LSB = FRAME_BITS - MAT_W - STATUS_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);
    localparam int WD_W       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
    localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYCLES - 1);

    logic w_clk_lvl, w_clk_rise, w_clk_fall;
    logic w_cs_lvl,  w_cs_rise,  w_cs_fall;
    logic w_di_lvl,  w_di_rise,  w_di_fall;

    zx_kbd_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_DET(1'b1)) u_sync_clk (
        .clk_i(CLK_14MHZ), .rst_i(RESET), .async_i(KBD_CLK),
        .sync_o(w_clk_lvl), .rise_o(w_clk_rise), .fall_o(w_clk_fall)
    );

    zx_kbd_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGE_DET(1'b1)) u_sync_cs (
        .clk_i(CLK_14MHZ), .rst_i(RESET), .async_i(KBD_CS),
        .sync_o(w_cs_lvl), .rise_o(w_cs_rise), .fall_o(w_cs_fall)
    );

    zx_kbd_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_DET(1'b0)) u_sync_di (
        .clk_i(CLK_14MHZ), .rst_i(RESET), .async_i(KBD_DI),
        .sync_o(w_di_lvl), .rise_o(w_di_rise), .fall_o(w_di_fall)
    );

    rx_state_e                state_q, state_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]    sr_q, sr_d;
    logic                     pend_fall_q, pend_fall_d;
    logic [MAT_W-1:0]         matrix_q, matrix_d;
    logic [STAT_KEEP-1:0]     status_q, status_d;
    logic [WD_W-1:0]          wd_q, wd_d;
    logic                     link_q, link_d;
    logic                     frame_ok_q, frame_err_q;
    logic [COLS-1:0]          kd_q, kd_d;
    logic                     w_commit, w_discard;
    logic [STATUS_BITS-1:0]   w_status;
    logic                     w_unused;

`ifdef KBD_KEMPSTON_EN
    logic [JOY_BITS-1:0]      joy_q, joy_d;
`endif

    assign w_status = sr_q[STATUS_LSB +: STATUS_BITS];

    // Receiver FSM: the frame is only judged once CS closes the envelope.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        pend_fall_d = 1'b0;
        w_commit    = 1'b0;
        w_discard   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (w_cs_fall || pend_fall_q) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    sr_d      = '0;
                end
            end
            ST_SHIFT: begin
                if (w_clk_rise) begin
                    sr_d = {sr_q[FRAME_BITS-2:0], w_di_lvl};
                    if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                if (w_cs_rise) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d     = ST_IDLE;
                pend_fall_d = w_cs_fall;
                if (bit_cnt_q == CNT_FULL) begin
                    w_commit = 1'b1;
                end else begin
                    w_discard = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Visible data: a commit beats a watchdog expiry landing in the same cycle.
    always_comb begin
        matrix_d = matrix_q;
        status_d = status_q;
        wd_d     = wd_q;
        link_d   = link_q;
`ifdef KBD_KEMPSTON_EN
        joy_d    = joy_q;
`endif
        if (w_commit) begin
            matrix_d = sr_q[FRAME_BITS-1 -: MAT_W];
            status_d = w_status[STAT_KEEP-1:0];
            wd_d     = WD_LOAD;
            link_d   = 1'b1;
`ifdef KBD_KEMPSTON_EN
            joy_d    = sr_q[JOY_BITS-1:0];
`endif
        end else if (wd_q == '0) begin
            matrix_d = '1;
            status_d = '0;
            link_d   = 1'b0;
`ifdef KBD_KEMPSTON_EN
            joy_d    = '0;
`endif
        end else begin
            wd_d = wd_q - WD_W'(1);
        end
    end

    always_comb begin
        kd_d = '1;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                kd_d[c] = kd_d[c] & (matrix_q[r*COLS + c] | A_HI[r]);
            end
        end
    end

    always_ff @(posedge CLK_14MHZ) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            pend_fall_q <= 1'b0;
            matrix_q    <= '1;
            status_q    <= '0;
            wd_q        <= '0;
            link_q      <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            kd_q        <= '1;
`ifdef KBD_KEMPSTON_EN
            joy_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            pend_fall_q <= pend_fall_d;
            matrix_q    <= matrix_d;
            status_q    <= status_d;
            wd_q        <= wd_d;
            link_q      <= link_d;
            frame_ok_q  <= w_commit;
            frame_err_q <= w_discard;
            kd_q        <= kd_d;
`ifdef KBD_KEMPSTON_EN
            joy_q       <= joy_d;
`endif
        end
    end

    assign KD            = kd_q;
    assign KBD_RESET_REQ = status_q[STAT_RESET_REQ];
    assign KBD_MAGIC     = status_q[STAT_MAGIC];
    assign KBD_TURBO     = status_q[STAT_TURBO];
    assign LINK_UP       = link_q;
    assign FRAME_OK      = frame_ok_q;
    assign FRAME_ERR     = frame_err_q;
`ifdef KBD_KEMPSTON_EN
    assign JOY           = joy_q;
`endif

    assign w_unused = ^{w_clk_lvl, w_clk_fall, w_cs_lvl, w_di_rise, w_di_fall,
                        w_status[STATUS_BITS-1:STAT_KEEP]};

endmodule
`default_nettype wire

// File: tb/tb_zx_kbd_spi_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_zx_kbd_spi_rx
// Description : Directed bench for zx_kbd_spi_rx against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zx_kbd_spi_rx;

`ifdef KBD_KEMPSTON_EN
    localparam int FB = 56;
`else
    localparam int FB = 48;
`endif
    localparam int TIMEOUT = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kbd_clk = 1'b0;
    logic       kbd_cs = 1'b1;
    logic       kbd_di = 1'b0;
    logic [7:0] a_hi = 8'hFF;
    logic [4:0] kd;
    logic       st_rr, st_mg, st_tb, link_up, frame_ok, frame_err;
`ifdef KBD_KEMPSTON_EN
    logic [7:0] joy;
`endif

    zx_kbd_spi_rx #(
        .SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT), .ROWS(8), .COLS(5)
    ) dut (
        .CLK_14MHZ(clk), .RESET(rst), .KBD_CLK(kbd_clk), .KBD_CS(kbd_cs),
        .KBD_DI(kbd_di), .A_HI(a_hi), .KD(kd),
        .KBD_RESET_REQ(st_rr), .KBD_MAGIC(st_mg), .KBD_TURBO(st_tb),
        .LINK_UP(link_up), .FRAME_OK(frame_ok),
`ifdef KBD_KEMPSTON_EN
        .FRAME_ERR(frame_err), .JOY(joy)
`else
        .FRAME_ERR(frame_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ok_cnt = 0, err_cnt = 0, exp_ok = 0, exp_err = 0;
    bit chk_en = 1'b0;

    // Model state: what the outputs must show, in frame terms.
    logic [39:0] mdl_m    = '1;
    logic [7:0]  mdl_st   = '0;
    logic [7:0]  mdl_joy  = '0;
    logic        mdl_link = 1'b0;
    logic [7:0]  a_prev   = 8'hFF;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] model_kd(input logic [39:0] m, input logic [7:0] a);
        logic [4:0] k = 5'h1F;
        for (int r = 0; r < 8; r++) begin
            if (!a[r]) k = k & m[r*5 +: 5];
        end
        return k;
    endfunction

    function automatic logic [39:0] press(input logic [39:0] m, input int r, input int c);
        logic [39:0] t = m;
        t[r*5 + c] = 1'b0;
        return t;
    endfunction

    always @(posedge clk) a_prev <= a_hi;

    always @(negedge clk) begin
        if (frame_ok)  ok_cnt  = ok_cnt + 1;
        if (frame_err) err_cnt = err_cnt + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("kd", {27'd0, kd}, {27'd0, model_kd(mdl_m, a_prev)});
            check("status", {29'd0, st_tb, st_mg, st_rr}, {29'd0, mdl_st[2:0]});
            check("link", {31'd0, link_up}, {31'd0, mdl_link});
            check("idle_pulses", {30'd0, frame_ok, frame_err}, 32'd0);
`ifdef KBD_KEMPSTON_EN
            check("joy", {24'd0, joy}, {24'd0, mdl_joy});
`endif
        end
    end

    task automatic send_bits(input int nbits, input logic [63:0] v);
        for (int i = nbits - 1; i >= 0; i--) begin
            kbd_di = v[i];
            repeat (2) @(negedge clk);
            kbd_clk = 1'b1;
            repeat (2) @(negedge clk);
            kbd_clk = 1'b0;
        end
    endtask

    task automatic send_frame(input int nbits, input logic [63:0] v);
        @(negedge clk);
        kbd_cs = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(nbits, v);
        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        kbd_cs = 1'b1;
        repeat (10) @(negedge clk);
        if (nbits == FB) begin
            mdl_m    = v[nbits-1 -: 40];
            mdl_st   = v[nbits-41 -: 8];
            mdl_joy  = (FB == 56) ? v[7:0] : 8'h00;
            mdl_link = 1'b1;
            exp_ok++;
        end else begin
            exp_err++;
        end
        check("ok_count", ok_cnt, exp_ok);
        check("err_count", err_cnt, exp_err);
        chk_en = 1'b1;
    endtask

    function automatic logic [63:0] frame(input logic [39:0] m, input logic [7:0] st,
                                          input logic [7:0] j);
        if (FB == 56) return {8'h00, m, st, j};
        return {16'h0000, m, st};
    endfunction

    task automatic set_a(input logic [7:0] a);
        @(negedge clk);
        a_hi = a;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [39:0] m;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_kd", {27'd0, kd}, 32'h1F);
        check("rst_link", {31'd0, link_up}, 32'd0);
        check("rst_status", {29'd0, st_tb, st_mg, st_rr}, 32'd0);
        chk_en = 1'b1;
        set_a(8'h00);
        check("rst_kd_all_rows", {27'd0, kd}, 32'h1F);

        // CAPS only
        m = press('1, 0, 0);
        send_frame(FB, frame(m, 8'h00, 8'h00));
        set_a(8'hFE);
        check("caps_fe", {27'd0, kd}, 32'h1E);
        set_a(8'hFD);
        check("caps_fd", {27'd0, kd}, 32'h1F);
        check("caps_link", {31'd0, link_up}, 32'd1);
        check("caps_one_ok", ok_cnt, 32'd1);

        // two rows
        m = press(press('1, 0, 1), 7, 4);
        send_frame(FB, frame(m, 8'h00, 8'h00));
        set_a(8'h7E);
        check("multi_7e", {27'd0, kd}, 32'h0D);
        set_a(8'h00);
        check("multi_00", {27'd0, kd}, 32'h0D);
        set_a(8'hFF);
        check("multi_ff", {27'd0, kd}, 32'h1F);

        // short and long frames carry all keys pressed; they must not land
        set_a(8'h00);
        send_frame(FB - 1, 64'h0);
        check("short_kd", {27'd0, kd}, 32'h0D);
        send_frame(FB + 1, 64'h0);
        check("long_kd", {27'd0, kd}, 32'h0D);
        check("err_two", err_cnt, 32'd2);

        send_frame(FB, frame(press('1, 3, 2), 8'h07, 8'h00));
        check("st_reset_req", {31'd0, st_rr}, 32'd1);
        check("st_magic", {31'd0, st_mg}, 32'd1);
        check("st_turbo", {31'd0, st_tb}, 32'd1);
        check("st_kd", {27'd0, kd}, 32'h1B);

        // watchdog expiry
        repeat (900) @(negedge clk);
        chk_en = 1'b0;
        repeat (200) @(negedge clk);
        mdl_m = '1; mdl_st = '0; mdl_joy = '0; mdl_link = 1'b0;
        chk_en = 1'b1;
        check("wd_link", {31'd0, link_up}, 32'd0);
        check("wd_kd", {27'd0, kd}, 32'h1F);
        check("wd_status", {29'd0, st_tb, st_mg, st_rr}, 32'd0);

        // reset in the middle of a frame
        @(negedge clk);
        kbd_cs = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(20, 64'h0);
        chk_en = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        kbd_cs = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_ok", ok_cnt, exp_ok);
        check("rst_mid_err", err_cnt, exp_err);
        chk_en = 1'b1;
        send_frame(FB, frame(press('1, 2, 3), 8'h04, 8'h00));
        set_a(8'hFB);
        check("rst_mid_kd", {27'd0, kd}, 32'h17);
        check("rst_mid_turbo", {31'd0, st_tb}, 32'd1);
        check("rst_mid_ok_total", ok_cnt, 32'd4);

        // 56-bit frame with joystick byte 0x11
        send_frame(56, {8'h00, press('1, 4, 3), 8'h00, 8'h11});
`ifdef KBD_KEMPSTON_EN
        check("joy_11", {24'd0, joy}, 32'h11);
`else
        check("frame56_err", err_cnt, 32'd3);
        set_a(8'hEF);
        check("frame56_kd_kept", {27'd0, kd}, 32'h1F);
`endif

        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
